// File: rtl/dsp48_slice.sv
// dsp48_slice: pipelined DSP slice modelled on the Spartan-6 DSP48A1.
// 18-bit pre-adder, 18x18 unsigned multiplier, 48-bit post-adder with carry.
// Each pipeline stage is a register or a wire, chosen by its *REG parameter.
// Optional macro DSP_CASCADE_OUT_EN adds the Bcout and Pcout cascade ports.
module dsp48_slice #(
    parameter int    A0REG       = 0,
    parameter int    A1REG       = 1,
    parameter int    B0REG       = 0,
    parameter int    B1REG       = 1,
    parameter int    CREG        = 1,
    parameter int    DREG        = 1,
    parameter int    MREG        = 1,
    parameter int    PREG        = 1,
    parameter int    CARRYINREG  = 1,
    parameter int    CARRYOUTREG = 1,
    parameter int    OPMODEREG   = 1,
    parameter string CARRYINSEL  = "OPMODE5",
    parameter string B_INPUT     = "DIRECT"
) (
    input  logic        Clk,
    input  logic        RstA,
    input  logic        RstB,
    input  logic        RstC,
    input  logic        RstD,
    input  logic        RstM,
    input  logic        RstP,
    input  logic        RstCarryin,
    input  logic        RstOpmode,
    input  logic        CEA,
    input  logic        CEB,
    input  logic        CEC,
    input  logic        CED,
    input  logic        CEM,
    input  logic        CEP,
    input  logic        CECarryin,
    input  logic        CEOpmode,
    input  logic [17:0] A,
    input  logic [17:0] B,
    input  logic [17:0] Bcin,
    input  logic [17:0] D,
    input  logic [47:0] C,
    input  logic [47:0] Pcin,
    input  logic        Carryin,
    input  logic [7:0]  Opmode,
`ifdef DSP_CASCADE_OUT_EN
    output logic [17:0] Bcout,
    output logic [47:0] Pcout,
`endif
    output logic [35:0] M,
    output logic [47:0] P,
    output logic        Carryout,
    output logic        CarryoutF
);

    logic [17:0] w_b_sel, w_a0, w_b0, w_d, w_a1, w_b1, w_preadd, w_b1_in;
    logic [47:0] w_c, w_p, w_x, w_z;
    logic [7:0]  w_op;
    logic [35:0] w_mult, w_m;
    logic        w_cin_sel, w_cin, w_co;
    logic [48:0] w_post;

    // Select the B operand source
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        w_b_sel = '0;
        if (B_INPUT == "DIRECT")       w_b_sel = B;
        else if (B_INPUT == "CASCADE") w_b_sel = Bcin;
    end

    // Stage-1 registers (A0, B0, D, C, Opmode): reset wins over clock enable
    if (A0REG == 1) begin : g_a0
        logic [17:0] r_a0;
        // Register A at the first stage
        always_ff @(posedge Clk or posedge RstA) begin
            // NOTE: non-blocking so every stage samples its pre-edge input.
            if (RstA) r_a0 <= '0; else if (CEA) r_a0 <= A;
        end
        assign w_a0 = r_a0;
    end else begin : g_a0_n
        assign w_a0 = A;
    end

    if (B0REG == 1) begin : g_b0
        logic [17:0] r_b0;
        // Register B at the first stage (pre-adder input)
        always_ff @(posedge Clk or posedge RstB) begin
            if (RstB) r_b0 <= '0; else if (CEB) r_b0 <= w_b_sel;
        end
        assign w_b0 = r_b0;
    end else begin : g_b0_n
        assign w_b0 = w_b_sel;
    end

    if (DREG == 1) begin : g_d
        logic [17:0] r_d;
        // Register the pre-adder D operand
        always_ff @(posedge Clk or posedge RstD) begin
            if (RstD) r_d <= '0; else if (CED) r_d <= D;
        end
        assign w_d = r_d;
    end else begin : g_d_n
        assign w_d = D;
    end

    if (CREG == 1) begin : g_c
        logic [47:0] r_c;
        // Register the post-adder C operand
        always_ff @(posedge Clk or posedge RstC) begin
            if (RstC) r_c <= '0; else if (CEC) r_c <= C;
        end
        assign w_c = r_c;
    end else begin : g_c_n
        assign w_c = C;
    end

    if (OPMODEREG == 1) begin : g_op
        logic [7:0] r_op;
        // Register Opmode; all datapath controls come from this stage
        always_ff @(posedge Clk or posedge RstOpmode) begin
            if (RstOpmode) r_op <= '0; else if (CEOpmode) r_op <= Opmode;
        end
        assign w_op = r_op;
    end else begin : g_op_n
        assign w_op = Opmode;
    end

    // Pre-adder wraps at 18 bits; Opmode[4] chooses it or raw B0 for B1
    assign w_preadd = w_op[6] ? (w_d - w_b0) : (w_d + w_b0);
    assign w_b1_in  = w_op[4] ? w_preadd : w_b0;

    if (A1REG == 1) begin : g_a1
        logic [17:0] r_a1;
        // Register A at the multiplier input
        always_ff @(posedge Clk or posedge RstA) begin
            if (RstA) r_a1 <= '0; else if (CEA) r_a1 <= w_a0;
        end
        assign w_a1 = r_a1;
    end else begin : g_a1_n
        assign w_a1 = w_a0;
    end

    if (B1REG == 1) begin : g_b1
        logic [17:0] r_b1;
        // Register B at the multiplier input (also the B cascade output)
        always_ff @(posedge Clk or posedge RstB) begin
            if (RstB) r_b1 <= '0; else if (CEB) r_b1 <= w_b1_in;
        end
        assign w_b1 = r_b1;
    end else begin : g_b1_n
        assign w_b1 = w_b1_in;
    end

    assign w_mult = {18'd0, w_a1} * {18'd0, w_b1};

    if (MREG == 1) begin : g_m
        logic [35:0] r_m;
        // Register the multiplier product
        always_ff @(posedge Clk or posedge RstM) begin
            if (RstM) r_m <= '0; else if (CEM) r_m <= w_mult;
        end
        assign w_m = r_m;
    end else begin : g_m_n
        assign w_m = w_mult;
    end

    // Select the carry-in source
    always_comb begin
        w_cin_sel = 1'b0;
        if (CARRYINSEL == "OPMODE5")      w_cin_sel = w_op[5];
        else if (CARRYINSEL == "CARRYIN") w_cin_sel = Carryin;
    end

    if (CARRYINREG == 1) begin : g_cin
        logic r_cin;
        // Register the selected carry-in
        always_ff @(posedge Clk or posedge RstCarryin) begin
            if (RstCarryin) r_cin <= 1'b0; else if (CECarryin) r_cin <= w_cin_sel;
        end
        assign w_cin = r_cin;
    end else begin : g_cin_n
        assign w_cin = w_cin_sel;
    end

    // X and Z operand multiplexers for the post-adder
    always_comb begin
        w_x = '0;
        w_z = '0;
        case (w_op[1:0])
            2'd1:    w_x = {12'd0, w_m};
            2'd2:    w_x = w_p;
            2'd3:    w_x = {w_d[11:0], w_a1, w_b1};
            default: w_x = '0;
        endcase
        case (w_op[3:2])
            2'd1:    w_z = Pcin;
            2'd2:    w_z = w_p;
            2'd3:    w_z = w_c;
            default: w_z = '0;
        endcase
    end

    // 49-bit post-adder: bit 48 is the carry (or borrow) out
    assign w_post = w_op[7] ? ({1'b0, w_z} - ({1'b0, w_x} + {48'd0, w_cin}))
                            : ({1'b0, w_z} + {1'b0, w_x} + {48'd0, w_cin});

    if (PREG == 1) begin : g_p
        logic [47:0] r_p;
        // Register the post-adder result
        always_ff @(posedge Clk or posedge RstP) begin
            if (RstP) r_p <= '0; else if (CEP) r_p <= w_post[47:0];
        end
        assign w_p = r_p;
    end else begin : g_p_n
        assign w_p = w_post[47:0];
    end

    if (CARRYOUTREG == 1) begin : g_co
        logic r_co;
        // Register the carry-out; shares the carry-in control group
        always_ff @(posedge Clk or posedge RstCarryin) begin
            if (RstCarryin) r_co <= 1'b0; else if (CECarryin) r_co <= w_post[48];
        end
        assign w_co = r_co;
    end else begin : g_co_n
        assign w_co = w_post[48];
    end

    assign M         = w_m;
    assign P         = w_p;
    assign Carryout  = w_co;
    assign CarryoutF = w_co;
`ifdef DSP_CASCADE_OUT_EN
    assign Bcout     = w_b1;
    assign Pcout     = w_p;
`endif

endmodule

// File: tb/tb_dsp48_slice.sv
// Directed testbench for dsp48_slice with default parameters.
// Expected values are hand-computed; inputs change 1ns after a rising edge
// and outputs are sampled at that same point, away from the edge.
module tb_dsp48_slice;

    logic        Clk = 1'b0;
    logic        RstA, RstB, RstC, RstD, RstM, RstP, RstCarryin, RstOpmode;
    logic        CEA, CEB, CEC, CED, CEM, CEP, CECarryin, CEOpmode;
    logic [17:0] A, B, Bcin, D;
    logic [47:0] C, Pcin;
    logic        Carryin;
    logic [7:0]  Opmode;
    logic [35:0] M;
    logic [47:0] P;
    logic        Carryout, CarryoutF;
`ifdef DSP_CASCADE_OUT_EN
    logic [17:0] Bcout;
    logic [47:0] Pcout;
`endif

    int n_checks = 0;
    int n_errors = 0;

    dsp48_slice u_dut (
        .Clk(Clk),
        .RstA(RstA), .RstB(RstB), .RstC(RstC), .RstD(RstD),
        .RstM(RstM), .RstP(RstP), .RstCarryin(RstCarryin), .RstOpmode(RstOpmode),
        .CEA(CEA), .CEB(CEB), .CEC(CEC), .CED(CED),
        .CEM(CEM), .CEP(CEP), .CECarryin(CECarryin), .CEOpmode(CEOpmode),
        .A(A), .B(B), .Bcin(Bcin), .D(D), .C(C), .Pcin(Pcin),
        .Carryin(Carryin), .Opmode(Opmode),
`ifdef DSP_CASCADE_OUT_EN
        .Bcout(Bcout), .Pcout(Pcout),
`endif
        .M(M), .P(P), .Carryout(Carryout), .CarryoutF(CarryoutF)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic set_rst(input logic v);
        {RstA, RstB, RstC, RstD, RstM, RstP, RstCarryin, RstOpmode} = {8{v}};
    endtask

    task automatic set_ce(input logic v);
        {CEA, CEB, CEC, CED, CEM, CEP, CECarryin, CEOpmode} = {8{v}};
    endtask

    task automatic drive(input logic [17:0] a, input logic [17:0] b, input logic [17:0] d,
                         input logic [47:0] c, input logic [7:0] op);
        A = a; B = b; D = d; C = c; Opmode = op;
    endtask

    initial begin
        set_rst(1'b0);
        set_ce(1'b0);
        drive(18'd0, 18'd0, 18'd0, 48'd0, 8'd0);
        Bcin = 18'd0; Pcin = 48'd0; Carryin = 1'b0;

        // Reset: outputs clear asynchronously, before any clock edge
        #1 set_rst(1'b1);
        #1;
        check("rst_async_p", P, 48'd0);
        check("rst_async_m", {12'd0, M}, 48'd0);
        check("rst_async_co", {47'd0, Carryout}, 48'd0);
        tick(10);
        check("rst_hold_p", P, 48'd0);
        check("rst_hold_m", {12'd0, M}, 48'd0);
        check("rst_hold_cof", {47'd0, CarryoutF}, 48'd0);
        set_rst(1'b0);
        set_ce(1'b1);

        // Multiply 6*7: M after edge 2, P on edge 3
        drive(18'd6, 18'd7, 18'd0, 48'd0, 8'b0000_0001);
        tick(1);
        check("mul_p_e1", P, 48'd0);
        tick(1);
        check("mul_m_e2", {12'd0, M}, 48'd42);
        check("mul_p_e2", P, 48'd0);
        tick(1);
        check("mul_p_e3", P, 48'd42);
`ifdef DSP_CASCADE_OUT_EN
        check("mul_bcout", {30'd0, Bcout}, 48'd7);
`endif

        // Pre-add: (30+10)*4
        drive(18'd4, 18'd10, 18'd30, 48'd0, 8'b0001_0001);
        tick(6);
        check("preadd_p", P, 48'd160);

        // Pre-subtract: (40-10)*3
        drive(18'd3, 18'd10, 18'd40, 48'd0, 8'b0101_0001);
        tick(6);
        check("presub_p", P, 48'd90);

        // Post-subtract: C - A*B = 100 - 30
        drive(18'd5, 18'd6, 18'd0, 48'd100, 8'b1000_1101);
        tick(6);
        check("postsub_p", P, 48'd70);
        check("postsub_co", {47'd0, Carryout}, 48'd0);

        // Post-subtract with borrow: 10 - 30 wraps, bit 48 set
        drive(18'd5, 18'd6, 18'd0, 48'd10, 8'b1000_1101);
        tick(6);
        check("borrow_p", P, 48'hFFFF_FFFF_FFEC);
        check("borrow_co", {47'd0, Carryout}, 48'd1);

        // Concatenation X = {D[11:0], A1, B1} plus C plus carry-in
        drive(18'd15, 18'd20, 18'd30, 48'd10, 8'b0110_1111);
        tick(6);
        check("concat_p", P, 48'd2061588234271);
        check("concat_co", {47'd0, Carryout}, 48'd0);
`ifdef DSP_CASCADE_OUT_EN
        check("concat_pcout", Pcout, 48'd2061588234271);
`endif

        // Accumulate P += 6 with CEP hold and RstP pulses
        CEP = 1'b0;
        drive(18'd2, 18'd3, 18'd0, 48'd0, 8'b0000_1001);
        tick(6);
        RstP = 1'b1;
        #1;
        check("acc_rstp_async", P, 48'd0);
        RstP = 1'b0;
        CEP = 1'b1;
        tick(1);
        check("acc_1", P, 48'd6);
        tick(1);
        check("acc_2", P, 48'd12);
        tick(1);
        check("acc_3", P, 48'd18);
        CEP = 1'b0;
        tick(3);
        check("acc_hold", P, 48'd18);
        CEP = 1'b1;
        tick(1);
        check("acc_resume", P, 48'd24);
        RstP = 1'b1;
        #1;
        check("acc_rstp_mid", P, 48'd0);
        RstP = 1'b0;
        tick(1);
        check("acc_after_rst_1", P, 48'd6);
        tick(1);
        check("acc_after_rst_2", P, 48'd12);
        check("acc_m", {12'd0, M}, 48'd6);

        // Wrap: (2^48 - 1) + 0 + 1 -> P = 0, carry out set
        drive(18'd2, 18'd3, 18'd0, 48'hFFFF_FFFF_FFFF, 8'b0010_1100);
        tick(6);
        check("wrap_p", P, 48'd0);
        check("wrap_co", {47'd0, Carryout}, 48'd1);
        check("wrap_cof", {47'd0, CarryoutF}, 48'd1);

        // All resets mid-cycle clear M and carry immediately
        set_rst(1'b1);
        #1;
        check("final_rst_m", {12'd0, M}, 48'd0);
        check("final_rst_co", {47'd0, Carryout}, 48'd0);
        check("final_rst_cof", {47'd0, CarryoutF}, 48'd0);
        check("final_rst_p", P, 48'd0);
        set_rst(1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dsp48_slice.md
Name: dsp48_slice

Overview:
- Configurable pipelined DSP slice in the style of the Spartan-6 DSP48A1.
- Datapath: 18-bit pre-adder/subtractor, 18x18 unsigned multiplier, 48-bit post-adder/subtractor with carry-in/carry-out.
- Pipeline depth, B-input source and carry-in source are set by parameters; the datapath is selected per cycle by an 8-bit Opmode.
- Used as the arithmetic primitive in filter/MAC datapaths; B and P cascade ports allow chaining slices.

Parameters:
- A0REG, 0, 1 = register A at the first stage; 0 = combinational.
- A1REG, 1, register A at the second stage (multiplier input).
- B0REG, 0, register B at the first stage (pre-adder input).
- B1REG, 1, register B at the second stage (multiplier input, also drives Bcout).
- CREG, 1, register C.
- DREG, 1, register D.
- MREG, 1, register the multiplier output.
- PREG, 1, register the post-adder output.
- CARRYINREG, 1, register the selected carry-in.
- CARRYOUTREG, 1, register the carry-out.
- OPMODEREG, 1, register Opmode.
- CARRYINSEL, "OPMODE5", carry-in source: "OPMODE5" = Opmode[5], "CARRYIN" = Carryin port; any other value = 0.
- B_INPUT, "DIRECT", B source: "DIRECT" = B, "CASCADE" = Bcin; any other value = 0.

Ports:
- Clk  in  1  rising-edge clock.
- RstA, RstB, RstC, RstD, RstM, RstP, RstCarryin, RstOpmode  in  1 each  asynchronous active-high resets, one per register group.
- CEA, CEB, CEC, CED, CEM, CEP, CECarryin, CEOpmode  in  1 each  clock enables, one per register group.
- A  in  18  multiplier operand.
- B  in  18  direct B operand.
- Bcin  in  18  cascade B operand.
- D  in  18  pre-adder operand.
- C  in  48  post-adder operand.
- Pcin  in  48  cascade P input.
- Carryin  in  1  external carry-in.
- Opmode  in  8  operation select.
- Bcout  out  18  B1 stage output.
- M  out  36  multiplier stage output.
- P  out  48  result.
- Pcout  out  48  equals P.
- Carryout  out  1  post-adder carry-out.
- CarryoutF  out  1  equals Carryout.

Behaviour:
- Every pipeline stage is a register when its *REG parameter = 1, otherwise a wire.
- Every register: async clear to 0 on its Rst; otherwise loads on a Clk rising edge when its CE = 1, else holds. Reset has priority over CE.
- Stage 1: A0, B0 (input from the B_INPUT mux), D, C, Opmode.
- Pre-adder: Opmode[6]=0 gives D+B0; Opmode[6]=1 gives D-B0. Result is 18 bits, modulo 2^18.
- Opmode[4]=1 feeds the pre-adder result to B1; Opmode[4]=0 feeds B0 to B1.
- B1 and A1 registers (CEB/RstB and CEA/RstA). Bcout = B1 output.
- Multiplier: A1 x B1, unsigned, 36-bit product, through the MREG stage (CEM/RstM). M = MREG stage output.
- X mux on Opmode[1:0]:
  - 0 → 0
  - 1 → M zero-extended to 48 bits
  - 2 → P
  - 3 → {D[11:0], A1, B1}
- Z mux on Opmode[3:2]:
  - 0 → 0
  - 1 → Pcin
  - 2 → P
  - 3 → C
- Carry-in: CARRYINSEL source through the CARRYINREG stage (CECarryin/RstCarryin).
- Post-adder, computed at 49 bits:
  - Opmode[7]=0: Z + X + CIN.
  - Opmode[7]=1: Z − (X + CIN).
  - Bits [47:0] go to PREG (CEP/RstP). Bit 48 goes to CARRYOUTREG, which also uses CECarryin/RstCarryin.
- All arithmetic wraps modulo the stated widths.
- Opmode is consumed at its OPMODEREG stage output. Each field applies to the stage it controls in the same cycle.
- Latency with default parameters, inputs held steady: A·B product appears on P three rising edges after the inputs are applied. Pre-adder paths take 4 edges because of the D register.
- P feedback (X or Z = P) uses the current P, giving one accumulation per enabled edge.
- Reset mid-operation clears only the targeted register group; downstream stages then propagate 0 on subsequent edges.
- All resets high: P, M, Bcout, Carryout = 0 immediately.

Optional Feature:
- Macro DSP_CASCADE_OUT_EN.
- Defined: the Bcout and Pcout ports exist as described.
- Undefined: Bcout and Pcout are omitted from the port list. All other behaviour is unchanged.

Test Plan:
- Reset: all Rst=1 for 10 cycles with CE=0 → P=0, M=0, Carryout=0, asynchronously, without waiting for Clk.
- Multiply: A=6, B=7, Opmode=8'b00000001, all CE=1 → M=42, then P=42 by the 3rd rising edge.
- Pre-add and pre-subtract:
  - D=30, B=10, A=4, Opmode=8'b00010001 → P=160.
  - Then D=40, B=10, A=3, Opmode=8'b01010001 → P=90.
- Post-subtract and concat:
  - C=100, A=5, B=6, Opmode=8'b10001101 → P=70, Carryout=0.
  - A=15, B=20, C=10, D=30, Opmode=8'b01101111 → P=2061588234271.
- Accumulate / CE hold:
  - A=2, B=3, Opmode=8'b00001001 → P rises by 6 each edge.
  - CEP=0 → P holds.
  - RstP pulse mid-run → P=0 at once, then resumes from 6.
- Wrap and carry: C=2^48−1, Opmode=8'b00101100 (Z=C, X=0, CIN=Opmode[5]=1) → P=0, Carryout=1, CarryoutF=1.
